hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 60 ++++++
 tb/tb_hazard_scoreboard.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: issue/operand/flow inputs and hazard outputs of the scoreboard; stall_cnt exists only with HAZARD_PERF_CNT_EN.
interface hazard_scoreboard_if #(parameter int ADDR_W = 5, parameter int LAT_W = 3);
  logic issue_vld;
  logic issue_we;
  logic [ADDR_W-1:0] issue_dst;
  logic [LAT_W-1:0] issue_lat;
  logic src0_re;
  logic src1_re;
  logic [ADDR_W-1:0] src0_addr;
  logic [ADDR_W-1:0] src1_addr;
  logic flow_change;
  logic hlt_in;
  logic stall;
  logic flush;
  logic byp0;
  logic byp1;
  logic hlt_out;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
  modport master (output issue_vld, issue_we, issue_dst, issue_lat, src0_re, src1_re, src0_addr, src1_addr,
                  flow_change, hlt_in, input stall, flush, byp0, byp1, hlt_out, stall_cnt);
  modport slave (input issue_vld, issue_we, issue_dst, issue_lat, src0_re, src1_re, src0_addr, src1_addr,
                 flow_change, hlt_in, output stall, flush, byp0, byp1, hlt_out, stall_cnt);
`else
  modport master (output issue_vld, issue_we, issue_dst, issue_lat, src0_re, src1_re, src0_addr, src1_addr,
                  flow_change, hlt_in, input stall, flush, byp0, byp1, hlt_out);
  modport slave (input issue_vld, issue_we, issue_dst, issue_lat, src0_re, src1_re, src0_addr, src1_addr,
                 flow_change, hlt_in, output stall, flush, byp0, byp1, hlt_out);
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard raising RAW/WAW stalls, bypass selects, flush and sticky halt.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int LAT_W = 3,
  parameter int FLUSH_CYC = 2
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);
  logic [LAT_W-1:0] cnt [NREG];
  logic [FW-1:0] fcnt;
  logic hlt_q, byp0_q, byp1_q;
  logic raw_hz, waw_hz, stall, flush, accept;
  logic rd0, rd1, wr;
  always_comb begin
    rd0 = bus.src0_re && bus.src0_addr != '0;
    rd1 = bus.src1_re && bus.src1_addr != '0;
    wr = bus.issue_we && bus.issue_dst != '0;
    raw_hz = (rd0 && cnt[bus.src0_addr] > ONE) || (rd1 && cnt[bus.src1_addr] > ONE);
    waw_hz = bus.issue_vld && wr && cnt[bus.issue_dst] > bus.issue_lat;
    stall = (bus.issue_vld && (raw_hz || waw_hz)) || hlt_q;
    flush = fcnt != '0 || bus.flow_change;
    accept = bus.issue_vld && !stall && !flush;
  end
  // Register 0 is hardwired, so its entry is forced to zero every cycle.
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      if (!rst_n || r == 0) cnt[r] <= '0;
      else if (accept && wr && bus.issue_dst == ADDR_W'(r) && bus.issue_lat != '0) cnt[r] <= bus.issue_lat;
      else if (cnt[r] != '0) cnt[r] <= cnt[r] - ONE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      fcnt <= '0;
      hlt_q <= 1'b0;
      byp0_q <= 1'b0;
      byp1_q <= 1'b0;
    end else begin
      fcnt <= bus.flow_change ? FW'(FLUSH_CYC) : (fcnt != '0 ? fcnt - 1'b1 : fcnt);
      hlt_q <= hlt_q || (accept && bus.hlt_in);
      byp0_q <= accept && rd0 && cnt[bus.src0_addr] == ONE;
      byp1_q <= accept && rd1 && cnt[bus.src1_addr] == ONE;
    end
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk)
    if (!rst_n) stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  assign bus.stall_cnt = stall_cnt;
`endif
  assign bus.stall = stall;
  assign bus.flush = flush;
  assign bus.byp0 = byp0_q;
  assign bus.byp1 = byp1_q;
  assign bus.hlt_out = hlt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors push expected {stall,flush,byp0,byp1,hlt_out}; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q [$];
  hazard_scoreboard_if #(.ADDR_W(5), .LAT_W(3)) bus ();
  hazard_scoreboard #(.ADDR_W(5), .LAT_W(3), .FLUSH_CYC(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      chk("stall", bus.stall, e[4]);
      chk("flush", bus.flush, e[3]);
      chk("byp0", bus.byp0, e[2]);
      chk("byp1", bus.byp1, e[1]);
      chk("hlt_out", bus.hlt_out, e[0]);
    end

  // e = {stall, flush, byp0, byp1, hlt_out} as seen at this cycle's negedge
  task automatic cyc(input logic [4:0] e, input logic rn, input logic vld, input logic we,
                     input logic [4:0] dst, input logic [2:0] lat, input logic re0, input logic [4:0] a0,
                     input logic re1, input logic [4:0] a1, input logic fc, input logic hi);
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.issue_vld = vld;
    bus.issue_we = we;
    bus.issue_dst = dst;
    bus.issue_lat = lat;
    bus.src0_re = re0;
    bus.src0_addr = a0;
    bus.src1_re = re1;
    bus.src1_addr = a1;
    bus.flow_change = fc;
    bus.hlt_in = hi;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.issue_vld = 0; bus.issue_we = 0; bus.issue_dst = 0; bus.issue_lat = 0;
    bus.src0_re = 0; bus.src0_addr = 0; bus.src1_re = 0; bus.src1_addr = 0;
    bus.flow_change = 0; bus.hlt_in = 0;
    //   exp      rn vld we dst lat re0 a0 re1 a1 fc hi
    cyc(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // RAW on a load result: one stall, then bypass
    cyc(5'b00000, 1, 1, 1, 3, 2, 0, 0, 0, 0, 0, 0);
    cyc(5'b10000, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    cyc(5'b00000, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    cyc(5'b00100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ALU result bypassed without stall; R0 never tracked
    cyc(5'b00000, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    cyc(5'b00000, 1, 1, 1, 0, 3, 0, 0, 1, 5, 0, 0);
    cyc(5'b00010, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // WAW: short write waits while cnt[R7] > 1
    cyc(5'b00000, 1, 1, 1, 7, 5, 0, 0, 0, 0, 0, 0);
    cyc(5'b10000, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc(5'b10000, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc(5'b10000, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc(5'b10000, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc(5'b00000, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // flush pulse with HLT in ID; then retrigger and a squashed write
    cyc(5'b01000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(5'b01000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(5'b01000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(5'b01000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(5'b01000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(5'b01000, 1, 1, 1, 9, 7, 0, 0, 0, 0, 0, 1);
    cyc(5'b01000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(5'b00000, 1, 1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    // long write pending, then halt, then reset clears everything
    cyc(5'b00000, 1, 1, 1, 6, 7, 0, 0, 0, 0, 0, 0);
    cyc(5'b00000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(5'b10001, 1, 1, 1, 4, 3, 0, 0, 0, 0, 0, 0);
    cyc(5'b10001, 1, 1, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    cyc(5'b10001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(5'b00000, 1, 1, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    cyc(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    tests++;
    if (bus.stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL stall_cnt after reset: got %0d expected 0", bus.stall_cnt);
    end
`endif
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
